// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates two write requesters onto one registered
// register-file write port and tracks pending writes per destination register.
module regfile_wb_sched #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          wb0_valid,
  output logic          wb0_ready,
  input  logic [AW-1:0] wb0_rd,
  input  logic [DW-1:0] wb0_data,
  input  logic          wb1_valid,
  output logic          wb1_ready,
  input  logic [AW-1:0] wb1_rd,
  input  logic [DW-1:0] wb1_data,
  output logic          regWriteEn,
  output logic [AW-1:0] rd_wb,
  output logic [DW-1:0] regWriteData,
  input  logic          rsv_valid,
  output logic          rsv_ready,
  input  logic [AW-1:0] rsv_rd,
  input  logic [AW-1:0] q_rj,
  input  logic [AW-1:0] q_rk,
  input  logic [AW-1:0] q_rd,
  output logic          busy_rj,
  output logic          busy_rk,
  output logic          busy_rd,
  output logic          err_underflow
);

  localparam int NREG = 2 ** AW;

  logic          lastGrant_q, lastGrant_d;
  logic          wrEn_q, wrEn_d;
  logic [AW-1:0] wrRd_q, wrRd_d;
  logic [DW-1:0] wrData_q, wrData_d;
  logic          underflow_q, underflow_d;
  logic [1:0]    cnt_q [NREG];
  logic [1:0]    cnt_d [NREG];

  logic          hsValid;
  logic [AW-1:0] hsRd;
  logic [DW-1:0] hsData;
  logic          rsvFire;
  logic          relFire;

  // lastGrant_q == 1 means requester 1 won the most recent handshake,
  // so requester 0 has priority on the next contention.
  always_comb begin
    wb0_ready   = wb0_valid & (~wb1_valid | lastGrant_q);
    wb1_ready   = wb1_valid & ~wb0_ready;
    hsValid     = wb0_ready | wb1_ready;
    hsRd        = wb0_ready ? wb0_rd : wb1_rd;
    hsData      = wb0_ready ? wb0_data : wb1_data;
    lastGrant_d = hsValid ? wb1_ready : lastGrant_q;
  end

  assign rsv_ready = (rsv_rd == '0) || (cnt_q[rsv_rd] != 2'd3);
  assign rsvFire   = rsv_valid & rsv_ready & (rsv_rd != '0);
  assign relFire   = hsValid & (hsRd != '0);

  // A reserve and a release hitting the same register cancel out; r0 never
  // sees either because both fire signals exclude index 0.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (rsvFire && (rsv_rd == AW'(r)) && !(relFire && (hsRd == AW'(r)))) begin
        cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (relFire && (hsRd == AW'(r)) && !(rsvFire && (rsv_rd == AW'(r)))
                   && (cnt_q[r] != 2'd0)) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
    underflow_d = underflow_q
                | (relFire && (cnt_q[hsRd] == 2'd0) && !(rsvFire && (rsv_rd == hsRd)));
    wrEn_d      = relFire;
    wrRd_d      = hsValid ? hsRd : wrRd_q;
    wrData_d    = hsValid ? hsData : wrData_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lastGrant_q <= 1'b1;
      wrEn_q      <= 1'b0;
      wrRd_q      <= '0;
      wrData_q    <= '0;
      underflow_q <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= 2'd0;
      end
    end else begin
      lastGrant_q <= lastGrant_d;
      wrEn_q      <= wrEn_d;
      wrRd_q      <= wrRd_d;
      wrData_q    <= wrData_d;
      underflow_q <= underflow_d;
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign regWriteEn    = wrEn_q;
  assign rd_wb         = wrRd_q;
  assign regWriteData  = wrData_q;
  assign err_underflow = underflow_q;

  assign busy_rj = (q_rj != '0) && (cnt_q[q_rj] != 2'd0);
  assign busy_rk = (q_rk != '0) && (cnt_q[q_rk] != 2'd0);
  assign busy_rd = (q_rd != '0) && (cnt_q[q_rd] != 2'd0);

endmodule
